gauss_feeder: RTL

GAUSS_FEEDER -- requirements
Module: gauss_feeder

---
 rtl/gauss_pkg.sv | 28 ++
 rtl/gauss_win_addr.sv | 77 +++++++
 rtl/gauss_feeder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// Shared types and constants for the Gaussian-filter feeder.
// The ERR state exists only when GAUSS_FEEDER_TIMEOUT_EN is defined.
package gauss_pkg;

  localparam int PIX_W = 8;

  localparam logic SEL_DATA = 1'b1;
  localparam logic SEL_CTRL = 1'b0;

  localparam logic [31:0] CTRL_START = 32'h1;

  typedef enum logic [3:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    WR_PIX,
    KICK,
    POLL,
    RD_RES,
    WR_OUT,
    NEXT,
    DONE
`ifdef GAUSS_FEEDER_TIMEOUT_EN
    , ERR
`endif
  } state_t;

endpackage

// File: rtl/gauss_win_addr.sv
// Window/tap counters and source/destination address generation.
// Counters start at window (1,1), tap 0 on load; the tap index runs i-major, j-minor.
module gauss_win_addr
  import gauss_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  input  logic        tap_adv,
  input  logic        win_adv,
  output logic [31:0] src_addr,
  output logic [31:0] dst_addr,
  output logic        taps_done,
  output logic        last_done
);

  logic [31:0] src_base_reg;
  logic [31:0] dst_base_reg;
  logic [31:0] out_idx_reg;
  logic [15:0] row_reg;
  logic [15:0] col_reg;
  logic [1:0]  ti_reg;
  logic [1:0]  tj_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_base_reg <= '0;
      dst_base_reg <= '0;
      out_idx_reg  <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      ti_reg       <= '0;
      tj_reg       <= '0;
    end else if (load) begin
      src_base_reg <= src_base;
      dst_base_reg <= dst_base;
      out_idx_reg  <= '0;
      row_reg      <= 16'd1;
      col_reg      <= 16'd1;
      ti_reg       <= '0;
      tj_reg       <= '0;
    end else if (win_adv) begin
      ti_reg      <= '0;
      tj_reg      <= '0;
      out_idx_reg <= out_idx_reg + 32'd1;
      if (col_reg == 16'(IMG_W - 2)) begin
        col_reg <= 16'd1;
        row_reg <= row_reg + 16'd1;
      end else begin
        col_reg <= col_reg + 16'd1;
      end
    end else if (tap_adv) begin
      if (tj_reg == 2'd2) begin
        tj_reg <= '0;
        ti_reg <= ti_reg + 2'd1;
      end else begin
        tj_reg <= tj_reg + 2'd1;
      end
    end
  end

  // ti reaching 3 means all nine taps of the window have been issued.
  always_comb begin
    src_addr  = src_base_reg
              + (32'(row_reg) + 32'(ti_reg) - 32'd1) * 32'(IMG_W)
              + 32'(col_reg) + 32'(tj_reg) - 32'd1;
    dst_addr  = dst_base_reg + out_idx_reg;
    taps_done = (ti_reg == 2'd3);
    last_done = (row_reg == 16'(IMG_H - 1));
  end

endmodule

// File: rtl/gauss_feeder.sv
// Streams 3x3 windows of a source image through a Gaussian peripheral, writing results out.
// Optional poll timeout with an ERR state is enabled by defining GAUSS_FEEDER_TIMEOUT_EN.
module gauss_feeder
  import gauss_pkg::*;
#(
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int POLL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] src_base_i,
  input  logic [31:0] dst_base_i,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        out_we_o,
  output logic [31:0] out_addr_o,
  output logic [7:0]  out_data_o,
  output logic        g_select_o,
  output logic        g_we_o,
  output logic [31:0] g_wdata_o,
  input  logic [31:0] g_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  state_t      state_reg;
  logic        start_ok;
  logic        tap_adv;
  logic        win_adv;
  logic        taps_done;
  logic        last_done;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        unused_bits;

`ifdef GAUSS_FEEDER_TIMEOUT_EN
  logic [31:0] poll_cnt_reg;
  logic        error_reg;
  assign start_ok = start_i && (state_reg == IDLE || state_reg == ERR);
  assign error_o  = error_reg;
`else
  assign start_ok = start_i && (state_reg == IDLE);
  assign error_o  = 1'b0;
`endif

  // Tap advances once its address is presented, window once its result is written,
  // so the registered address loaded on the next transition is already current.
  assign tap_adv     = (state_reg == RD_ADDR);
  assign win_adv     = (state_reg == WR_OUT);
  assign unused_bits = ^{g_rdata_i[31:PIX_W], POLL_TIMEOUT[0]};

  gauss_win_addr #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_win_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .src_base (src_base_i),
    .dst_base (dst_base_i),
    .tap_adv  (tap_adv),
    .win_adv  (win_adv),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .taps_done(taps_done),
    .last_done(last_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      g_we_o     <= 1'b0;
      out_we_o   <= 1'b0;
      g_select_o <= SEL_CTRL;
      g_wdata_o  <= '0;
      mem_addr_o <= '0;
      out_addr_o <= '0;
      out_data_o <= '0;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
      poll_cnt_reg <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      g_we_o   <= 1'b0;
      out_we_o <= 1'b0;
      done_o   <= 1'b0;
      if (start_ok) begin
        // First tap of window (1,1) is pixel (0,0), i.e. the source base itself.
        state_reg  <= RD_ADDR;
        busy_o     <= 1'b1;
        g_select_o <= SEL_CTRL;
        mem_addr_o <= src_base_i;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
        error_reg  <= 1'b0;
`endif
      end else begin
        case (state_reg)
          RD_ADDR: state_reg <= RD_WAIT;
          RD_WAIT: begin
            state_reg  <= WR_PIX;
            g_select_o <= SEL_DATA;
            g_we_o     <= 1'b1;
            g_wdata_o  <= {{(32 - PIX_W){1'b0}}, mem_rdata_i};
          end
          WR_PIX: begin
            if (taps_done) begin
              state_reg  <= KICK;
              g_select_o <= SEL_CTRL;
              g_we_o     <= 1'b1;
              g_wdata_o  <= CTRL_START;
            end else begin
              state_reg  <= RD_ADDR;
              mem_addr_o <= src_addr;
            end
          end
          KICK: begin
            state_reg <= POLL;
`ifdef GAUSS_FEEDER_TIMEOUT_EN
            poll_cnt_reg <= '0;
`endif
          end
          POLL: begin
            if (!g_rdata_i[0]) begin
              state_reg  <= RD_RES;
              g_select_o <= SEL_DATA;
            end
`ifdef GAUSS_FEEDER_TIMEOUT_EN
            else if (poll_cnt_reg == 32'(POLL_TIMEOUT - 1)) begin
              state_reg <= ERR;
              busy_o    <= 1'b0;
              error_reg <= 1'b1;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + 32'd1;
            end
`endif
          end
          RD_RES: begin
            state_reg  <= WR_OUT;
            g_select_o <= SEL_CTRL;
            out_we_o   <= 1'b1;
            out_addr_o <= dst_addr;
            out_data_o <= g_rdata_i[PIX_W-1:0];
          end
          WR_OUT: state_reg <= NEXT;
          NEXT: begin
            if (last_done) begin
              state_reg <= DONE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              state_reg  <= RD_ADDR;
              mem_addr_o <= src_addr;
            end
          end
          DONE: state_reg <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule
